// File: rtl/csel_add_pipe.sv
// csel_add_pipe: two-stage pipelined carry-select adder/subtractor with
// valid/ready flow control. Stage 1 forms conditional slice sums and slice
// generate/propagate; stage 2 resolves slice carries with a Kogge-Stone
// prefix, selects the slice sums and derives the flags.
module csel_add_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NB  = WIDTH / BLOCK;
    localparam int unsigned LVL = $clog2(NB);
    localparam int unsigned BW  = BLOCK + 1;

    // Stage 1 state
    logic                         s1_valid_q, s1_valid_d;
    logic [NB-1:0][BLOCK-1:0]     sum0_q, sum0_d;
    logic [NB-1:0][BLOCK-1:0]     sum1_q, sum1_d;
    logic [NB-1:0]                g_q, g_d;
    logic [NB-1:0]                p_q, p_d;
    logic                         c_eff_q, c_eff_d;
    logic                         a_msb_q, a_msb_d;
    logic                         b_msb_q, b_msb_d;

    // Stage 2 (output) state
    logic                         out_valid_q, out_valid_d;
    logic [WIDTH-1:0]             sum_q, sum_d;
    logic                         cout_q, cout_d;
    logic                         ovf_q, ovf_d;
    logic                         zero_q, zero_d;

    // Combinational helpers
    logic [WIDTH-1:0]             b_eff;
    logic                         c_eff;
    logic                         s2_free;
    logic                         s1_adv;
    logic [BW-1:0]                t0, t1;
    logic [LVL:0][NB-1:0]         gl, pl;
    logic [NB-1:0]                slice_c;
    logic [WIDTH-1:0]             res;
    logic                         res_cout;

    // Handshake: ready flows combinationally from out_ready back to in_ready
    always_comb begin
        s2_free  = ~out_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_free;
        in_ready = rst | ~s1_valid_q | s2_free;
    end

    // Operand preparation: subtract is A + ~B + 1
    always_comb begin
        b_eff = sub ? ~b : b;
        c_eff = sub | cin;
    end

    // Stage 1 next state: both conditional slice sums plus slice G/P
    always_comb begin
        s1_valid_d = s1_valid_q;
        sum0_d     = sum0_q;
        sum1_d     = sum1_q;
        g_d        = g_q;
        p_d        = p_q;
        c_eff_d    = c_eff_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        t0         = '0;
        t1         = '0;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                for (int unsigned k = 0; k < NB; k++) begin
                    t0 = BW'(a[k*BLOCK +: BLOCK]) + BW'(b_eff[k*BLOCK +: BLOCK]);
                    t1 = t0 + BW'(1);
                    sum0_d[k] = t0[BLOCK-1:0];
                    sum1_d[k] = t1[BLOCK-1:0];
                    g_d[k]    = t0[BLOCK];
                    p_d[k]    = t1[BLOCK] ^ t0[BLOCK];
                end
                c_eff_d = c_eff;
                a_msb_d = a[WIDTH-1];
                b_msb_d = b_eff[WIDTH-1];
            end
        end
    end

    // Kogge-Stone prefix over the registered slice G/P vectors
    always_comb begin
        gl    = '0;
        pl    = '0;
        gl[0] = g_q;
        pl[0] = p_q;
        for (int unsigned i = 0; i < LVL; i++) begin
            for (int unsigned j = 0; j < NB; j++) begin
                if (j >= (32'd1 << i)) begin
                    gl[i+1][j] = gl[i][j] | (pl[i][j] & gl[i][j - (32'd1 << i)]);
                    pl[i+1][j] = pl[i][j] & pl[i][j - (32'd1 << i)];
                end else begin
                    gl[i+1][j] = gl[i][j];
                    pl[i+1][j] = pl[i][j];
                end
            end
        end
    end

    // Slice carries and carry-select of the final sum
    always_comb begin
        slice_c    = '0;
        slice_c[0] = c_eff_q;
        for (int unsigned k = 1; k < NB; k++) begin
            slice_c[k] = gl[LVL][k-1] | (pl[LVL][k-1] & c_eff_q);
        end
        res = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            res[k*BLOCK +: BLOCK] = slice_c[k] ? sum1_q[k] : sum0_q[k];
        end
        res_cout = gl[LVL][NB-1] | (pl[LVL][NB-1] & c_eff_q);
    end

    // Stage 2 next state: result and flags load when stage 1 advances
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            sum_d  = res;
            cout_d = res_cout;
            ovf_d  = (a_msb_q == b_msb_q) & (res[WIDTH-1] != a_msb_q);
            zero_d = ~|res;
        end
    end

    // Pipeline registers; reset discards any in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            sum0_q      <= '0;
            sum1_q      <= '0;
            g_q         <= '0;
            p_q         <= '0;
            c_eff_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            sum0_q      <= sum0_d;
            sum1_q      <= sum1_d;
            g_q         <= g_d;
            p_q         <= p_d;
            c_eff_q     <= c_eff_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_csel_add_pipe.sv
// Bench for csel_add_pipe: three instances (32/4, 16/2, 8/4) share stimulus;
// expected results come from a WIDTH+1-bit reference sum kept in queues.
module tb_csel_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] sum32;
    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] sum16;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]  sum8;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [34:0] q32[$];
    logic [34:0] q16[$];
    logic [34:0] q8[$];

    always #5 clk = ~clk;

    csel_add_pipe #(.WIDTH(32), .BLOCK(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid32), .out_ready(out_ready),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    csel_add_pipe #(.WIDTH(16), .BLOCK(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    csel_add_pipe #(.WIDTH(8), .BLOCK(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    // Reference: {zero, ovf, cout, sum} from a w+1-bit addition
    function automatic logic [34:0] ref_model(input logic [31:0] a_i, input logic [31:0] b_i,
                                              input logic cin_i, input logic sub_i, input int w);
        logic [32:0] mask;
        logic [32:0] aa;
        logic [32:0] bb;
        logic [32:0] full;
        logic [31:0] s;
        logic        co;
        logic        ov;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a_i} & mask;
        bb   = (sub_i ? ~{1'b0, b_i} : {1'b0, b_i}) & mask;
        full = aa + bb + 33'(sub_i | cin_i);
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {(s == 32'd0), ov, co, s};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [34:0] got32();
        return {zero32, ovf32, cout32, sum32};
    endfunction

    function automatic logic [34:0] got16();
        return {zero16, ovf16, cout16, 16'h0, sum16};
    endfunction

    function automatic logic [34:0] got8();
        return {zero8, ovf8, cout8, 24'h0, sum8};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (out_valid32 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid32);
            else pass_cnt++;
            chk_cnt++;
            if (got32() !== 35'd0) $display("FAIL reset_result: got %h expected 0", got32());
            else pass_cnt++;
            chk_cnt++;
            if (in_ready32 !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready32);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (in_ready32 !== 1'b1) $display("FAIL reset_release_in_ready: got %b expected 1", in_ready32);
        else pass_cnt++;
        chk_cnt++;
        if (out_valid32 !== 1'b0) $display("FAIL reset_release_out_valid: got %b expected 0", out_valid32);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[5];
        logic [31:0] vb[5];
        logic        vc[5];
        logic        vs[5];
        logic [34:0] ve[5];
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vc[0] = 1'b0; vs[0] = 1'b0; ve[0] = {1'b1, 1'b0, 1'b1, 32'h0000_0000};
        va[1] = 32'h5;         vb[1] = 32'h7; vc[1] = 1'b1; vs[1] = 1'b1; ve[1] = {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE};
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h1; vc[2] = 1'b0; vs[2] = 1'b0; ve[2] = {1'b0, 1'b1, 1'b0, 32'h8000_0000};
        va[3] = 32'h8000_0000; vb[3] = 32'h1; vc[3] = 1'b0; vs[3] = 1'b1; ve[3] = {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF};
        va[4] = 32'h1;         vb[4] = 32'h2; vc[4] = 1'b1; vs[4] = 1'b0; ve[4] = {1'b0, 1'b0, 1'b0, 32'h0000_0004};
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            in_valid = 1'b1; a = va[v]; b = vb[v]; cin = vc[v]; sub = vs[v];
            @(negedge clk);
            chk_cnt++;
            if (in_ready32 !== 1'b1) $display("FAIL directed%0d_in_ready: got %b expected 1", v, in_ready32);
            else pass_cnt++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk_cnt++;
            if (out_valid32 !== 1'b0) $display("FAIL directed%0d_early_valid: got %b expected 0", v, out_valid32);
            else pass_cnt++;
            @(posedge clk); #1;
            @(negedge clk);
            chk_cnt++;
            if (out_valid32 !== 1'b1) $display("FAIL directed%0d_out_valid: got %b expected 1", v, out_valid32);
            else pass_cnt++;
            chk_cnt++;
            if (got32() !== ve[v]) $display("FAIL directed%0d_result: got %h expected %h", v, got32(), ve[v]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          done = 0;
        int          cyc  = 0;
        logic        held = 1'b0;
        logic [31:0] held_sum = '0;
        logic [34:0] exp;
        logic        exp_rdy;
        q32.delete();
        while ((sent < 8 || done < 8) && cyc < 40) begin
            in_valid  = (sent < 8);
            out_ready = !(cyc >= 3 && cyc <= 5);
            a = 32'h1111_1111 * 32'(sent + 1); b = 32'h0F0F_0F0F + 32'(sent); cin = sent[0]; sub = sent[1];
            @(negedge clk);
            exp_rdy = !(q32.size() == 2 && !out_ready);
            chk_cnt++;
            if (in_ready32 !== exp_rdy) $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, in_ready32, exp_rdy);
            else pass_cnt++;
            if (held) begin
                chk_cnt++;
                if (out_valid32 !== 1'b1 || sum32 !== held_sum)
                    $display("FAIL bp_hold cyc%0d: got %b/%h expected 1/%h", cyc, out_valid32, sum32, held_sum);
                else pass_cnt++;
            end
            if (out_valid32 && out_ready) begin
                chk_cnt++;
                if (q32.size() == 0) $display("FAIL bp_extra_beat cyc%0d: got %h expected none", cyc, got32());
                else begin
                    exp = q32.pop_front();
                    if (got32() !== exp) $display("FAIL bp_result%0d: got %h expected %h", done, got32(), exp);
                    else pass_cnt++;
                end
                done++;
            end
            if (in_valid && in_ready32) begin
                q32.push_back(ref_model(a, b, cin, sub, 32));
                sent++;
            end
            held     = out_valid32 && !out_ready;
            held_sum = sum32;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (done != 8 || q32.size() != 0) $display("FAIL bp_count: got %0d delivered expected 8", done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'h1234_5678; b = 32'h1; cin = 1'b0; sub = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (in_ready32 !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready32);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (out_valid32 !== 1'b0 || out_valid16 !== 1'b0 || out_valid8 !== 1'b0)
                $display("FAIL midrst_no_delivery%0d: got %b%b%b expected 000", c, out_valid32, out_valid16, out_valid8);
            else pass_cnt++;
            if (c == 0) begin
                chk_cnt++;
                if (in_ready32 !== 1'b1) $display("FAIL midrst_release_in_ready: got %b expected 1", in_ready32);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int beats);
        int          acc = 0;
        int          cyc = 0;
        logic [34:0] exp;
        logic        exp_rdy;
        q32.delete(); q16.delete(); q8.delete();
        while ((acc < beats || q32.size() != 0 || q16.size() != 0 || q8.size() != 0) && cyc < 80000) begin
            in_valid  = (acc < beats) && ($urandom_range(3) != 0);
            out_ready = (acc >= beats) || ($urandom_range(3) != 0);
            a = rand_op(); b = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            exp_rdy = !(q32.size() == 2 && !out_ready);
            chk_cnt++;
            if (in_ready32 !== exp_rdy) $display("FAIL rnd_in_ready cyc%0d: got %b expected %b", cyc, in_ready32, exp_rdy);
            else pass_cnt++;
            if (out_valid32 && out_ready) begin
                chk_cnt++;
                if (q32.size() == 0) $display("FAIL rnd32_extra cyc%0d: got %h expected none", cyc, got32());
                else begin
                    exp = q32.pop_front();
                    if (got32() !== exp) $display("FAIL rnd32_result cyc%0d: got %h expected %h", cyc, got32(), exp);
                    else pass_cnt++;
                end
            end
            if (out_valid16 && out_ready) begin
                chk_cnt++;
                if (q16.size() == 0) $display("FAIL rnd16_extra cyc%0d: got %h expected none", cyc, got16());
                else begin
                    exp = q16.pop_front();
                    if (got16() !== exp) $display("FAIL rnd16_result cyc%0d: got %h expected %h", cyc, got16(), exp);
                    else pass_cnt++;
                end
            end
            if (out_valid8 && out_ready) begin
                chk_cnt++;
                if (q8.size() == 0) $display("FAIL rnd8_extra cyc%0d: got %h expected none", cyc, got8());
                else begin
                    exp = q8.pop_front();
                    if (got8() !== exp) $display("FAIL rnd8_result cyc%0d: got %h expected %h", cyc, got8(), exp);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready32) begin
                q32.push_back(ref_model(a, b, cin, sub, 32));
                acc++;
            end
            if (in_valid && in_ready16) q16.push_back(ref_model(a, b, cin, sub, 16));
            if (in_valid && in_ready8)  q8.push_back(ref_model(a, b, cin, sub, 8));
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (acc != beats || q32.size() != 0 || q16.size() != 0 || q8.size() != 0)
            $display("FAIL rnd_drain: got %0d accepted, %0d/%0d/%0d pending expected %0d, 0/0/0",
                     acc, q32.size(), q16.size(), q8.size(), beats);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(10000);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
